fetch_queue: RTL and testbench

- Parametrised instruction prefetch unit: the next-generation replacement for the single-slot fetch path.
- Keeps up to DEPTH instructions buffered ahead of the core, fetched sequentially from paged program memory over the shared memory handshake (req/cack/ready/busy).
- On a core redirect (branch, irq vector, sreg PC write) it flushes and discards in-flight data.
- Sits between the core decoder/PC logic and the memory arbiter.

---
 rtl/fetch_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_queue.sv | 557 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch unit. Keeps up to DEPTH instructions buffered ahead of
// the core, fetched sequentially from paged program memory over the shared
// req/cack/ready/busy memory handshake. One memory request is outstanding at
// most. A core redirect flushes the queue and retargets fetch. Data from a
// request that was already in flight at the time of the redirect is dropped
// when it returns.
//
// Parameters
//   ADDR_W   program word-address width
//   PAGE_W   program page width (memory address is PAGE_W+ADDR_W bits)
//   INSTR_W  instruction width
//   DEPTH    queue entries (power of two, >= 2)
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   redirect     flush queue, restart fetch at redir_page:redir_addr
//   redir_addr   new fetch word address
//   redir_page   new fetch page
//   instr_valid  queue head valid
//   instr_ready  core consumes the head this cycle
//   instr_out    head instruction
//   instr_addr   word address of the head instruction
//   mem_req      fetch request to the memory arbiter
//   mem_addr     {page, fetch_pc} of the current request
//   mem_busy     arbiter busy; no new request may start
//   mem_cack     request accepted (1-cycle pulse)
//   mem_ready    read data valid (1-cycle pulse)
//   mem_data     read data
//   queue_count  number of occupied queue entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int ADDR_W  = 16,
    parameter int PAGE_W  = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redir_addr,
    input  logic [PAGE_W-1:0]         redir_page,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [INSTR_W-1:0]        instr_out,
    output logic [ADDR_W-1:0]         instr_addr,
    output logic                      mem_req,
    output logic [PAGE_W+ADDR_W-1:0]  mem_addr,
    input  logic                      mem_busy,
    input  logic                      mem_cack,
    input  logic                      mem_ready,
    input  logic [INSTR_W-1:0]        mem_data,
    output logic [$clog2(DEPTH):0]    queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MEM_W = PAGE_W + ADDR_W;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Fetch handshake states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // ------------------------------------------------------------------
    // Fetch state
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [PAGE_W-1:0] r_page;
    logic              r_discard;
    logic [MEM_W-1:0]  r_req_addr;

    // ------------------------------------------------------------------
    // Queue state
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] r_q_instr [DEPTH];
    logic [ADDR_W-1:0]  r_q_addr  [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic             w_in_flight;
    logic             w_issue;
    logic             w_return;
    logic             w_push;
    logic             w_pop;
    logic [MEM_W-1:0] w_issue_addr;

    // A request is outstanding from the moment it is presented until its data
    // returns; a redirect in that window must drop the returning word.
    assign w_in_flight = (r_state == S_REQ) || (r_state == S_WAIT);

    // Space is reserved at issue time: with a single outstanding request and
    // count < DEPTH here, the eventual push can never overflow the queue.
    assign w_issue = (r_state == S_IDLE) && !mem_busy && (r_count < FULL_COUNT);

    assign w_return = (r_state == S_WAIT) && mem_ready;

    // Redirect has priority over both push and pop in the same cycle.
    assign w_push = w_return && !r_discard && !redirect;
    assign w_pop  = instr_valid && instr_ready && !redirect;

    // A redirect arriving in the issuing cycle must already steer the request
    // that is being launched, since fetch_pc only updates at the same edge.
    assign w_issue_addr = redirect ? {redir_page, redir_addr} : {r_page, r_fetch_pc};

    // ------------------------------------------------------------------
    // Handshake FSM: IDLE -> REQ -> WAIT -> IDLE
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // w_state_nxt unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue)   w_state_nxt = S_REQ;
            S_REQ:   if (mem_cack)  w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= '0;
            r_page     <= '0;
            r_discard  <= 1'b0;
            r_req_addr <= '0;
        end else begin
            r_state <= w_state_nxt;

            // The request address is captured once at issue and held until
            // cack, so a redirect during REQ never disturbs mem_addr.
            if (w_issue) begin
                r_req_addr <= w_issue_addr;
            end

            // fetch_pc wraps within the page; the page never advances on its own.
            if (redirect) begin
                r_fetch_pc <= redir_addr;
                r_page     <= redir_page;
            end else if (w_return && !r_discard) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end

            // A return always consumes the discard flag. A redirect that lands
            // on the same edge as the return already drops that return via
            // w_push, so it must not mark the next request for discard.
            if (w_return) begin
                r_discard <= 1'b0;
            end else if (redirect && w_in_flight) begin
                r_discard <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever read while
    // r_count says it holds pushed data, so its power-up contents are unused.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= mem_data;
            r_q_addr[r_wr_ptr]  <= r_fetch_pc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The head is read straight from registered storage, so a word pushed
    // into an empty queue appears on instr_out the cycle after mem_ready.
    assign instr_valid = (r_count != '0);
    assign instr_out   = r_q_instr[r_rd_ptr];
    assign instr_addr  = r_q_addr[r_rd_ptr];
    assign queue_count = r_count;

    assign mem_req  = (r_state == S_REQ);
    assign mem_addr = r_req_addr;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (default parameters). A behavioural
// memory answers requests with data = {page,addr} ^ 0xA5A5A5A5, either
// automatically (fixed or random latencies) or under direct task control.
// The core side is scored against a simple sequential-address model: after a
// redirect to page:addr, the core must see addr, addr+1, ... (wrapping within
// the page) with the matching memory words.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redir_addr;
    logic [7:0]  redir_page;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [15:0] instr_addr;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_busy;
    logic        mem_cack;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [2:0]  queue_count;

    // Memory responder: automatic part and directly driven part.
    logic        auto_cack;
    logic        auto_ready;
    logic [31:0] auto_data;
    logic        man_cack;
    logic        man_ready;
    logic [31:0] man_data;
    logic        mem_auto;
    logic        mem_rand;
    logic        mem_flush;

    int n_checks;
    int n_fail;

    assign mem_cack  = auto_cack | man_cack;
    assign mem_ready = auto_ready | man_ready;
    assign mem_data  = auto_ready ? auto_data : man_data;

    fetch_queue #(
        .ADDR_W (16),
        .PAGE_W (8),
        .INSTR_W(32),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redir_addr (redir_addr),
        .redir_page (redir_page),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out  (instr_out),
        .instr_addr (instr_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_busy   (mem_busy),
        .mem_cack   (mem_cack),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .queue_count(queue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {8'h00, a} ^ 32'hA5A5A5A5;
    endfunction

    // Behavioural program memory: accepts a request after a wait, returns the
    // word a few cycles after accepting it. Drives on the falling edge.
    initial begin : mem_model
        int          mstage;
        int          wcnt;
        int          rcnt;
        logic [23:0] cap_addr;
        auto_cack  = 1'b0;
        auto_ready = 1'b0;
        auto_data  = '0;
        mstage     = 0;
        wcnt       = 0;
        rcnt       = 0;
        cap_addr   = '0;
        forever begin
            @(negedge clk);
            auto_cack  = 1'b0;
            auto_ready = 1'b0;
            if (mem_flush || !mem_auto) begin
                mstage = 0;
                wcnt   = 0;
            end else if (mstage == 0) begin
                if (mem_req) begin
                    if (wcnt > 0) begin
                        wcnt--;
                    end else begin
                        auto_cack = 1'b1;
                        cap_addr  = mem_addr;
                        mstage    = 1;
                        rcnt      = mem_rand ? int'($urandom_range(1, 4)) : 2;
                    end
                end
            end else begin
                if (rcnt > 1) begin
                    rcnt--;
                end else begin
                    auto_ready = 1'b1;
                    auto_data  = mem_word(cap_addr);
                    mstage     = 0;
                    wcnt       = mem_rand ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle; sampling and driving happen 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        mem_busy    = 1'b1;
        redirect    = 1'b0;
        redir_addr  = '0;
        redir_page  = '0;
        instr_ready = 1'b0;
        man_cack    = 1'b0;
        man_ready   = 1'b0;
        man_data    = '0;
        mem_flush   = 1'b1;
        repeat (3) tick();
        rst       = 1'b0;
        mem_flush = 1'b0;
        tick();
    endtask

    task automatic redirect_to(input logic [7:0] page, input logic [15:0] addr);
        redirect   = 1'b1;
        redir_page = page;
        redir_addr = addr;
        tick();
        redirect = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        mem_auto = 1'b0;
        mem_rand = 1'b0;
        reset_dut();
        n_checks++;
        if (queue_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", queue_count);
        end
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid);
        end
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_sequential();
        int          n;
        bit          req_seen;
        logic [15:0] exp_a;
        reset_dut();
        mem_auto    = 1'b1;
        mem_rand    = 1'b0;
        instr_ready = 1'b1;
        redirect_to(8'h02, 16'h0010);
        mem_busy = 1'b0;
        n        = 0;
        req_seen = 1'b0;
        for (int b = 0; b < 80 && n < 3; b++) begin
            if (mem_req && !req_seen) begin
                req_seen = 1'b1;
                n_checks++;
                if (mem_addr !== 24'h020010) begin
                    n_fail++; $display("FAIL seq_first_addr: got %h expected 020010", mem_addr);
                end
            end
            if (instr_valid) begin
                exp_a = 16'h0010 + 16'(n);
                n_checks++;
                if (instr_addr !== exp_a) begin
                    n_fail++; $display("FAIL seq_addr: got %h expected %h", instr_addr, exp_a);
                end
                n_checks++;
                if (instr_out !== mem_word({8'h02, exp_a})) begin
                    n_fail++; $display("FAIL seq_data: got %h expected %h", instr_out, mem_word({8'h02, exp_a}));
                end
                n++;
            end
            tick();
        end
        n_checks++;
        if (n != 3) begin
            n_fail++; $display("FAIL seq_delivered: got %0d expected 3", n);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        int          n_req;
        int          n;
        bit          rose;
        logic [15:0] exp_a;
        reset_dut();
        mem_auto    = 1'b1;
        mem_rand    = 1'b0;
        instr_ready = 1'b0;
        redirect_to(8'h01, 16'h0040);
        mem_busy = 1'b0;
        n_req    = 0;
        repeat (60) begin
            if (mem_cack) n_req++;
            tick();
        end
        n_checks++;
        if (n_req != 4) begin
            n_fail++; $display("FAIL full_requests: got %0d expected 4", n_req);
        end
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL full_req_idle: got %b expected 0", mem_req);
        end
        n_checks++;
        if (queue_count !== 3'd4) begin
            n_fail++; $display("FAIL full_count: got %0d expected 4", queue_count);
        end
        n_checks++;
        if (instr_addr !== 16'h0040) begin
            n_fail++; $display("FAIL full_head: got %h expected 0040", instr_addr);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_checks++;
        if (queue_count !== 3'd3) begin
            n_fail++; $display("FAIL full_pop_count: got %0d expected 3", queue_count);
        end
        rose = 1'b0;
        for (int i = 0; i < 2 && !rose; i++) begin
            tick();
            if (mem_req) rose = 1'b1;
        end
        n_checks++;
        if (!rose) begin
            n_fail++; $display("FAIL full_resume: got no request expected request within 2 cycles");
        end
        instr_ready = 1'b1;
        n = 0;
        for (int b = 0; b < 80 && n < 5; b++) begin
            if (instr_valid) begin
                exp_a = 16'h0041 + 16'(n);
                n_checks++;
                if (instr_addr !== exp_a || instr_out !== mem_word({8'h01, exp_a})) begin
                    n_fail++; $display("FAIL full_drain: got %h/%h expected %h/%h",
                                       instr_addr, instr_out, exp_a, mem_word({8'h01, exp_a}));
                end
                n++;
            end
            tick();
        end
        n_checks++;
        if (n != 5) begin
            n_fail++; $display("FAIL full_drain_count: got %0d expected 5", n);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_redirect_wait();
        int n;
        bit found;
        bit got;
        reset_dut();
        mem_auto    = 1'b1;
        mem_rand    = 1'b0;
        instr_ready = 1'b1;
        redirect_to(8'h00, 16'h0010);
        mem_busy = 1'b0;
        n        = 0;
        found    = 1'b0;
        for (int b = 0; b < 100 && !found; b++) begin
            if (instr_valid) begin
                n_checks++;
                if (instr_addr !== 16'h0010 + 16'(n)) begin
                    n_fail++; $display("FAIL rw_pre_addr: got %h expected %h", instr_addr, 16'h0010 + 16'(n));
                end
                n++;
            end
            // cack visible here means the DUT is already waiting for 0x0013
            if (mem_cack && mem_addr == 24'h000013) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rw_reach_wait: got no request for 0013 expected one");
        end
        redirect_to(8'h00, 16'h0100);
        n_checks++;
        if (queue_count !== 3'd0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL rw_flush: got count %0d valid %b expected 0/0", queue_count, instr_valid);
        end
        got = 1'b0;
        for (int b = 0; b < 40 && !got; b++) begin
            if (instr_valid) begin
                got = 1'b1;
                n_checks++;
                if (instr_addr !== 16'h0100) begin
                    n_fail++; $display("FAIL rw_next_addr: got %h expected 0100", instr_addr);
                end
                n_checks++;
                if (instr_out !== mem_word(24'h000100)) begin
                    n_fail++; $display("FAIL rw_next_data: got %h expected %h", instr_out, mem_word(24'h000100));
                end
            end
            tick();
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL rw_timeout: got nothing expected instruction 0100");
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_collision();
        reset_dut();
        mem_auto    = 1'b0;
        instr_ready = 1'b0;
        redirect_to(8'h00, 16'h0200);
        mem_busy = 1'b0;
        for (int b = 0; b < 10 && !mem_req; b++) tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h000200) begin
            n_fail++; $display("FAIL col_req0: got req %b addr %h expected 1/000200", mem_req, mem_addr);
        end
        man_cack = 1'b1; tick(); man_cack = 1'b0; tick();
        man_ready = 1'b1; man_data = mem_word(24'h000200); tick(); man_ready = 1'b0;
        n_checks++;
        if (queue_count !== 3'd1) begin
            n_fail++; $display("FAIL col_fill: got %0d expected 1", queue_count);
        end
        for (int b = 0; b < 10 && !mem_req; b++) tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h000201) begin
            n_fail++; $display("FAIL col_req1: got req %b addr %h expected 1/000201", mem_req, mem_addr);
        end
        man_cack = 1'b1; tick(); man_cack = 1'b0;
        // redirect, pop and returning data all hit the same edge
        instr_ready = 1'b1;
        man_ready   = 1'b1;
        man_data    = mem_word(24'h000201);
        redirect_to(8'h00, 16'h0300);
        instr_ready = 1'b0;
        man_ready   = 1'b0;
        n_checks++;
        if (queue_count !== 3'd0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL col_flush: got count %0d valid %b expected 0/0", queue_count, instr_valid);
        end
        for (int b = 0; b < 10 && !mem_req; b++) tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h000300) begin
            n_fail++; $display("FAIL col_req2: got req %b addr %h expected 1/000300", mem_req, mem_addr);
        end
        man_cack = 1'b1; tick(); man_cack = 1'b0;
        man_ready = 1'b1; man_data = mem_word(24'h000300); tick(); man_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 16'h0300 || instr_out !== mem_word(24'h000300)) begin
            n_fail++; $display("FAIL col_after: got valid %b addr %h data %h expected 1/0300/%h",
                               instr_valid, instr_addr, instr_out, mem_word(24'h000300));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_page_wrap();
        logic [23:0] exp_full [2];
        int          n_c;
        int          n;
        exp_full[0] = 24'h05FFFF;
        exp_full[1] = 24'h050000;
        reset_dut();
        mem_auto    = 1'b1;
        mem_rand    = 1'b0;
        instr_ready = 1'b1;
        redirect_to(8'h05, 16'hFFFF);
        mem_busy = 1'b0;
        n_c = 0;
        n   = 0;
        for (int b = 0; b < 60 && n < 2; b++) begin
            if (mem_cack && n_c < 2) begin
                n_checks++;
                if (mem_addr !== exp_full[n_c]) begin
                    n_fail++; $display("FAIL wrap_mem_addr: got %h expected %h", mem_addr, exp_full[n_c]);
                end
                n_c++;
            end
            if (instr_valid) begin
                n_checks++;
                if (instr_addr !== exp_full[n][15:0] || instr_out !== mem_word(exp_full[n])) begin
                    n_fail++; $display("FAIL wrap_deliver: got %h/%h expected %h/%h",
                                       instr_addr, instr_out, exp_full[n][15:0], mem_word(exp_full[n]));
                end
                n++;
            end
            tick();
        end
        n_checks++;
        if (n != 2) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected 2", n);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_busy_and_reset();
        reset_dut();
        mem_auto = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (mem_req !== 1'b0) begin
                n_fail++; $display("FAIL busy_req: got %b expected 0 at cycle %0d", mem_req, i);
            end
            tick();
        end
        mem_busy = 1'b0;
        for (int b = 0; b < 10 && !mem_req; b++) tick();
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL busy_release: got %b expected 1", mem_req);
        end
        man_cack = 1'b1; tick(); man_cack = 1'b0;
        // DUT now waits for data; reset it mid-transaction
        rst = 1'b1; tick(); rst = 1'b0;
        mem_busy = 1'b1;
        n_checks++;
        if (mem_req !== 1'b0 || queue_count !== 3'd0) begin
            n_fail++; $display("FAIL rst_wait: got req %b count %0d expected 0/0", mem_req, queue_count);
        end
        man_ready = 1'b1; man_data = 32'hDEADBEEF; tick(); man_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (queue_count !== 3'd0 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL stray_ready: got count %0d valid %b expected 0/0", queue_count, instr_valid);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [7:0]  exp_page;
        bit          do_redir;
        bit          outst;
        int          consumed;
        reset_dut();
        mem_auto = 1'b1;
        mem_rand = 1'b1;
        exp_page = 8'($urandom);
        exp_pc   = 16'($urandom);
        redirect_to(exp_page, exp_pc);
        outst    = 1'b0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 1) == 1);
            mem_busy    = ($urandom_range(0, 3) == 0);
            do_redir    = ($urandom_range(0, 49) == 0);
            redirect    = do_redir;
            if (do_redir) begin
                redir_page = 8'($urandom);
                redir_addr = ($urandom_range(0, 1) == 1) ? 16'hFFFE : 16'($urandom);
            end
            n_checks++;
            if (queue_count > 3'd4 || instr_valid !== (queue_count != 3'd0)) begin
                n_fail++; $display("FAIL rnd_count: got count %0d valid %b", queue_count, instr_valid);
            end
            n_checks++;
            if (mem_req && outst) begin
                n_fail++; $display("FAIL rnd_outstanding: got new request with one outstanding expected none");
            end
            if (mem_cack) outst = 1'b1;
            if (mem_ready) outst = 1'b0;
            if (instr_valid && instr_ready && !do_redir) begin
                n_checks++;
                if (instr_addr !== exp_pc || instr_out !== mem_word({exp_page, exp_pc})) begin
                    n_fail++; $display("FAIL rnd_deliver: got %h/%h expected %h/%h",
                                       instr_addr, instr_out, exp_pc, mem_word({exp_page, exp_pc}));
                end
                exp_pc = exp_pc + 16'd1;
                consumed++;
            end
            if (do_redir) begin
                exp_pc   = redir_addr;
                exp_page = redir_page;
            end
            tick();
        end
        redirect    = 1'b0;
        instr_ready = 1'b0;
        n_checks++;
        if (consumed < 50) begin
            n_fail++; $display("FAIL rnd_progress: got %0d instructions expected at least 50", consumed);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        mem_auto    = 1'b0;
        mem_rand    = 1'b0;
        mem_flush   = 1'b1;
        rst         = 1'b1;
        redirect    = 1'b0;
        redir_addr  = '0;
        redir_page  = '0;
        instr_ready = 1'b0;
        mem_busy    = 1'b1;
        man_cack    = 1'b0;
        man_ready   = 1'b0;
        man_data    = '0;

        test_reset();
        test_sequential();
        test_full();
        test_redirect_wait();
        test_collision();
        test_page_wrap();
        test_busy_and_reset();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
